// File: rtl/multi_xfer_seq.sv
// Register/address sequencer for multi-register memory ops (LA/SA block, LM/SM mask).
// Emits one transfer per cycle; comp stays low until the final transfer is presented.
module multi_xfer_seq #(
  parameter int DATA_W    = 16,
  parameter int NREG      = 8,
  parameter int RA_W      = 3,
  parameter int LA_COUNT  = 7,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [NREG-1:0]   imm_mask,
  input  logic [DATA_W-1:0] RF_d1,
  input  logic              hold,
  output logic              comp,
  output logic [RA_W-1:0]   regr,
  output logic [DATA_W-1:0] memloc,
  output logic              xfer_valid,
  output logic              is_store,
  output logic [RA_W:0]     xfer_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DATA_W-1:0] STEP    = DATA_W'(ADDR_STEP);
  localparam logic [RA_W:0]     CNT_ONE = (RA_W+1)'(1);
  localparam logic [NREG-1:0]   BIT_ONE = NREG'(1);

  state_t            state_reg, state_next;
  logic [NREG-1:0]   mask_reg, mask_next;
  logic [DATA_W-1:0] base_reg, base_next;
  logic [RA_W:0]     cnt_reg, cnt_next;
  logic              store_reg, store_next;

  logic [NREG-1:0]   la_mask;
  logic [NREG-1:0]   new_list;
  logic [NREG-1:0]   cur_list;
  logic [NREG-1:0]   low_bit;
  logic [RA_W-1:0]   enc_idx;
  logic              is_multi;
  logic              single;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_la_mask
      assign la_mask[gi] = (gi < LA_COUNT);
    end
  endgenerate

  // LM=0110, SM=0111, LA=1110, SA=1111 are exactly the codes with bits [2:1] set
  assign is_multi = (opcode[2:1] == 2'b11);
  assign new_list = opcode[3] ? la_mask : imm_mask;
  assign cur_list = (state_reg == IDLE) ? new_list : mask_reg;
  assign low_bit  = cur_list & (~cur_list + BIT_ONE);
  assign single   = ((cur_list & (cur_list - BIT_ONE)) == '0);

  // Priority encoder: lowest set bit of the remaining list wins
  always_comb begin
    enc_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (cur_list[i]) enc_idx = RA_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    base_next  = base_reg;
    cnt_next   = cnt_reg;
    store_next = store_reg;
    comp       = 1'b1;
    regr       = '0;
    memloc     = '0;
    xfer_valid = 1'b0;
    is_store   = 1'b0;
    xfer_idx   = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (is_multi && (new_list != '0)) begin
            regr       = enc_idx;
            memloc     = RF_d1;
            xfer_valid = !hold;
            is_store   = opcode[0];
            comp       = single;
            if (!hold && !single) begin
              state_next = RUN;
              base_next  = RF_d1 + STEP;
              mask_next  = new_list & ~low_bit;
              cnt_next   = CNT_ONE;
              store_next = opcode[0];
            end
          end
        end
        RUN: begin
          if (!is_multi) begin
            // Abort: present defaults and drop the partial sequence
            state_next = IDLE;
            mask_next  = '0;
            base_next  = '0;
            cnt_next   = '0;
          end else begin
            regr       = enc_idx;
            memloc     = base_reg;
            xfer_valid = !hold;
            is_store   = store_reg;
            xfer_idx   = cnt_reg;
            comp       = single;
            if (!hold) begin
              if (single) begin
                state_next = IDLE;
                mask_next  = '0;
                base_next  = '0;
                cnt_next   = '0;
              end else begin
                mask_next  = mask_reg & ~low_bit;
                base_next  = base_reg + STEP;
                cnt_next   = cnt_reg + CNT_ONE;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      base_reg  <= '0;
      cnt_reg   <= '0;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      base_reg  <= base_next;
      cnt_reg   <= cnt_next;
      store_reg <= store_next;
    end
  end

endmodule

// File: tb/tb_multi_xfer_seq.sv
// Scoreboard bench for multi_xfer_seq: a list-based reference model queues expected
// outputs per cycle; a negedge monitor pops and compares them against the DUT.
module tb_multi_xfer_seq;
  localparam int DATA_W = 16, NREG = 8, RA_W = 3, LA_COUNT = 7, ADDR_STEP = 1;
  localparam logic [3:0] OP_LM = 4'b0110, OP_SM = 4'b0111, OP_LA = 4'b1110, OP_SA = 4'b1111;

  logic clk = 1'b0;
  logic rst, hold, comp, xfer_valid, is_store;
  logic [3:0] opcode;
  logic [NREG-1:0] imm_mask;
  logic [DATA_W-1:0] RF_d1, memloc;
  logic [RA_W-1:0] regr;
  logic [RA_W:0] xfer_idx;

  multi_xfer_seq #(.DATA_W(DATA_W), .NREG(NREG), .RA_W(RA_W), .LA_COUNT(LA_COUNT),
                   .ADDR_STEP(ADDR_STEP)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imm_mask(imm_mask), .RF_d1(RF_d1),
    .hold(hold), .comp(comp), .regr(regr), .memloc(memloc), .xfer_valid(xfer_valid),
    .is_store(is_store), .xfer_idx(xfer_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic comp;
    logic [RA_W-1:0] regr;
    logic [DATA_W-1:0] memloc;
    logic valid;
    logic st;
    logic [RA_W:0] idx;
  } exp_t;

  typedef struct {
    int r;
    logic [DATA_W-1:0] a;
    int k;
  } xfer_t;

  exp_t  exp_q[$];
  xfer_t pend[$];
  logic  m_store;
  logic  last_comp;
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;

  // Reference: the instruction's whole transfer list is built up front, then consumed.
  task automatic model(input logic r, input logic [3:0] op, input logic [NREG-1:0] m,
                       input logic [DATA_W-1:0] a, input logic h);
    exp_t  e;
    xfer_t lst[$];
    xfer_t x;
    logic  multi;
    int    k;
    e = '{comp: 1'b1, regr: '0, memloc: '0, valid: 1'b0, st: 1'b0, idx: '0};
    multi = (op == OP_LM) || (op == OP_SM) || (op == OP_LA) || (op == OP_SA);
    if (r) begin
      pend.delete();
    end else if (pend.size() == 0) begin
      if (multi) begin
        k = 0;
        for (int i = 0; i < NREG; i++) begin
          if ((op[3] && i < LA_COUNT) || (!op[3] && m[i])) begin
            x.r = i; x.a = a + DATA_W'(k * ADDR_STEP); x.k = k;
            lst.push_back(x);
            k++;
          end
        end
        if (lst.size() > 0) begin
          e.comp = (lst.size() == 1); e.regr = RA_W'(lst[0].r); e.memloc = lst[0].a;
          e.valid = !h; e.st = op[0]; e.idx = '0;
          if (!h && lst.size() > 1) begin
            pend = lst;
            void'(pend.pop_front());
            m_store = op[0];
          end
        end
      end
    end else if (!multi) begin
      pend.delete();
    end else begin
      e.comp = (pend.size() == 1); e.regr = RA_W'(pend[0].r); e.memloc = pend[0].a;
      e.valid = !h; e.st = m_store; e.idx = (RA_W+1)'(pend[0].k);
      if (!h) void'(pend.pop_front());
    end
    last_comp = e.comp;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic [NREG-1:0] m,
                      input logic [DATA_W-1:0] a, input logic h);
    rst = r; opcode = op; imm_mask = m; RF_d1 = a; hold = h;
    model(r, op, m, a, h);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("comp", 32'(comp), 32'(e.comp));
      chk("xfer_valid", 32'(xfer_valid), 32'(e.valid));
      chk("regr", 32'(regr), 32'(e.regr));
      chk("memloc", 32'(memloc), 32'(e.memloc));
      chk("xfer_idx", 32'(xfer_idx), 32'(e.idx));
      if (e.valid) chk("is_store", 32'(is_store), 32'(e.st));
      if (xfer_valid)
        $display("xfer cyc=%0d idx=%0d regr=%0d memloc=0x%04h store=%0b comp=%0b",
                 cyc, xfer_idx, regr, memloc, is_store, comp);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ops [4];
    logic [3:0] op, cur_op;
    logic [NREG-1:0] mk;
    logic [DATA_W-1:0] ad;
    logic h, r;
    int guard;
    ops[0] = OP_LM; ops[1] = OP_SM; ops[2] = OP_LA; ops[3] = OP_SA;
    rst = 1'b1; opcode = '0; imm_mask = '0; RF_d1 = '0; hold = 1'b0;
    @(posedge clk); #1;
    step(1, 4'h0, 8'h00, 16'h0000, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // LA block from 0x0100, then a non-multi opcode
    for (int i = 0; i < 7; i++) step(0, OP_LA, 8'h00, 16'h0100, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // SM with address wrap
    for (int i = 0; i < 4; i++) step(0, OP_SM, 8'b10100101, 16'hFFFE, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // Empty and single-bit LM
    for (int i = 0; i < 3; i++) step(0, OP_LM, 8'h00, 16'h1234, 0);
    step(0, OP_LM, 8'b00010000, 16'h4321, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // LA with a 2-cycle hold at regr=3
    for (int i = 0; i < 3; i++) step(0, OP_LA, 8'h00, 16'h0300, 0);
    step(0, OP_LA, 8'h00, 16'h0300, 1);
    step(0, OP_LA, 8'h00, 16'h0300, 1);
    for (int i = 0; i < 4; i++) step(0, OP_LA, 8'h00, 16'h0300, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // Reset mid-SA at regr=4, then restart
    for (int i = 0; i < 4; i++) step(0, OP_SA, 8'h00, 16'h0200, 0);
    step(1, OP_SA, 8'h00, 16'h0200, 0);
    for (int i = 0; i < 7; i++) step(0, OP_SA, 8'h00, 16'h0200, 0);
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    // Abort SA at regr=2, then a fresh LA
    for (int i = 0; i < 2; i++) step(0, OP_SA, 8'h00, 16'h0500, 0);
    step(0, 4'h0, 8'h00, 16'h0500, 0);
    step(0, 4'h0, 8'h00, 16'h0500, 0);
    for (int i = 0; i < 7; i++) step(0, OP_LA, 8'h00, 16'h0600, 0);
    // Randomized instruction stream with holds, aborts, resets and back-to-back ops
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0: mk = '0;
        1: mk = NREG'(1) << $urandom_range(0, NREG - 1);
        default: mk = NREG'($urandom);
      endcase
      ad = DATA_W'($urandom);
      guard = 0;
      while (1) begin
        h = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 80) == 0);
        cur_op = op;
        if (pend.size() > 0 && !h && $urandom_range(0, 25) == 0) cur_op = 4'h0;
        if (pend.size() > 0)
          step(r, cur_op, NREG'($urandom), DATA_W'($urandom), h);
        else
          step(r, cur_op, mk, ad, h);
        guard++;
        if (r || (last_comp && !h) || guard > 40) break;
      end
      if ($urandom_range(0, 3) == 0) step(0, 4'h0, NREG'($urandom), DATA_W'($urandom), 0);
    end
    step(0, 4'h0, 8'h00, 16'h0000, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
